// File: rtl/forwarding_scoreboard.sv
// Tracks in-flight register writers across DEPTH post-ID slots, selects the youngest
// forwardable producer per ID source operand, and stalls ID while a result is not yet ready.
module forwarding_scoreboard #(
    parameter int NB_REG = 5,
    parameter int N_SRC  = 2,
    parameter int DEPTH  = 3,
    parameter int NB_SEL = 3,
    parameter int NB_CNT = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid_ID,
    input  logic                    i_flush,
    input  logic [N_SRC*NB_REG-1:0] i_src_ID,
    input  logic [N_SRC-1:0]        i_src_used_ID,
    input  logic [NB_REG-1:0]       i_rd_ID,
    input  logic                    i_RegWrite_ID,
    input  logic [NB_SEL-1:0]       i_ready_stage_ID,
    output logic                    o_stall,
    output logic [N_SRC*NB_SEL-1:0] o_fwd_sel,
    output logic                    o_fwd_valid,
    output logic [NB_CNT-1:0]       o_stall_count
);

    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [DEPTH-1:0]        wr_q, wr_d;
    logic [NB_REG-1:0]       rd_q  [DEPTH];
    logic [NB_REG-1:0]       rd_d  [DEPTH];
    logic [NB_SEL-1:0]       rdy_q [DEPTH];
    logic [NB_SEL-1:0]       rdy_d [DEPTH];
    logic [N_SRC*NB_SEL-1:0] fwd_sel_q, fwd_sel_d;
    logic                    fwd_valid_q, fwd_valid_d;
    logic [NB_CNT-1:0]       stall_count_q, stall_count_d;

    logic [N_SRC*NB_SEL-1:0] sel_s;
    logic [N_SRC-1:0]        hazard_s;
    logic                    stall_s;
    logic                    issue_s;
    logic [NB_SEL-1:0]       rdy_in_s;

    // Youngest-match search per operand; a match in the last slot reads the register file
    always_comb begin : match_comb
        logic              found;
        logic [NB_REG-1:0] src;
        sel_s    = {(N_SRC*NB_SEL){1'b0}};
        hazard_s = {N_SRC{1'b0}};
        found    = 1'b0;
        src      = {NB_REG{1'b0}};
        for (int s = 0; s < N_SRC; s++) begin
            found = 1'b0;
            src   = i_src_ID[s*NB_REG +: NB_REG];
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && i_src_used_ID[s] && (src != {NB_REG{1'b0}}) &&
                    valid_q[k] && wr_q[k] && (rd_q[k] == src)) begin
                    found = 1'b1;
                    if (k < DEPTH - 1) begin
                        sel_s[s*NB_SEL +: NB_SEL] = NB_SEL'(k + 1);
                        hazard_s[s]               = (NB_SEL'(k + 1) < rdy_q[k]);
                    end else begin
                        sel_s[s*NB_SEL +: NB_SEL] = {NB_SEL{1'b0}};
                        hazard_s[s]               = 1'b0;
                    end
                end else begin
                    found = found;
                end
            end
        end
    end

    // Stall/issue decision; flush suppresses both
    always_comb begin
        stall_s  = i_valid_ID & ~i_flush & (|hazard_s);
        issue_s  = i_valid_ID & ~i_flush & ~(|hazard_s);
        if (i_ready_stage_ID == {NB_SEL{1'b0}}) begin
            rdy_in_s = NB_SEL'(1);
        end else begin
            rdy_in_s = i_ready_stage_ID;
        end
    end

    // Next state: slot shift, slot-0 load or bubble, select register and stall counter
    always_comb begin
        valid_d       = {DEPTH{1'b0}};
        wr_d          = {DEPTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            rd_d[k]  = {NB_REG{1'b0}};
            rdy_d[k] = {NB_SEL{1'b0}};
        end
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            wr_d[k]    = wr_q[k-1];
            rd_d[k]    = rd_q[k-1];
            rdy_d[k]   = rdy_q[k-1];
        end
        if (issue_s) begin
            valid_d[0]  = 1'b1;
            wr_d[0]     = i_RegWrite_ID & (i_rd_ID != {NB_REG{1'b0}});
            rd_d[0]     = i_rd_ID;
            rdy_d[0]    = rdy_in_s;
            fwd_sel_d   = sel_s;
            fwd_valid_d = 1'b1;
        end else begin
            valid_d[0]  = 1'b0;
            fwd_sel_d   = {(N_SRC*NB_SEL){1'b0}};
            fwd_valid_d = 1'b0;
        end
        if (stall_s && (stall_count_q != {NB_CNT{1'b1}})) begin
            stall_count_d = stall_count_q + NB_CNT'(1);
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q       <= {DEPTH{1'b0}};
            wr_q          <= {DEPTH{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                rd_q[k]  <= {NB_REG{1'b0}};
                rdy_q[k] <= {NB_SEL{1'b0}};
            end
            fwd_sel_q     <= {(N_SRC*NB_SEL){1'b0}};
            fwd_valid_q   <= 1'b0;
            stall_count_q <= {NB_CNT{1'b0}};
        end else begin
            valid_q       <= valid_d;
            wr_q          <= wr_d;
            for (int k = 0; k < DEPTH; k++) begin
                rd_q[k]  <= rd_d[k];
                rdy_q[k] <= rdy_d[k];
            end
            fwd_sel_q     <= fwd_sel_d;
            fwd_valid_q   <= fwd_valid_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign o_stall       = stall_s;
    assign o_fwd_sel     = fwd_sel_q;
    assign o_fwd_valid   = fwd_valid_q;
    assign o_stall_count = stall_count_q;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Randomized and directed bench for forwarding_scoreboard against an issue-history model.
module tb_forwarding_scoreboard;

    localparam int NB_REG = 5;
    localparam int N_SRC  = 2;
    localparam int DEPTH  = 3;
    localparam int NB_SEL = 3;
    localparam int NB_CNT = 16;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    valid_id = 1'b0;
    logic                    flush = 1'b0;
    logic [N_SRC*NB_REG-1:0] src_id = '0;
    logic [N_SRC-1:0]        used_id = '0;
    logic [NB_REG-1:0]       rd_id = '0;
    logic                    rw_id = 1'b0;
    logic [NB_SEL-1:0]       rdy_id = '0;
    logic                    stall;
    logic [N_SRC*NB_SEL-1:0] fwd_sel;
    logic                    fwd_valid;
    logic [NB_CNT-1:0]       stall_count;

    logic                    v2 = 1'b0;
    logic [N_SRC*NB_REG-1:0] src2 = '0;
    logic [N_SRC-1:0]        used2 = '0;
    logic [NB_REG-1:0]       rd2 = '0;
    logic                    rw2 = 1'b0;
    logic [NB_SEL-1:0]       rdy2 = '0;
    logic                    stall2;
    logic [N_SRC*NB_SEL-1:0] sel2;
    logic                    fv2;
    logic [1:0]              cnt2;

    int checks = 0;
    int errors = 0;
    int obs_stall;

    typedef struct {
        bit v;
        int rd;
        bit w;
        int rdy;
    } hist_t;
    hist_t hist[$];
    int    mcnt;

    always #5 clk = ~clk;

    forwarding_scoreboard #(.NB_REG(NB_REG), .N_SRC(N_SRC), .DEPTH(DEPTH),
                            .NB_SEL(NB_SEL), .NB_CNT(NB_CNT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid_ID(valid_id), .i_flush(flush),
        .i_src_ID(src_id), .i_src_used_ID(used_id), .i_rd_ID(rd_id),
        .i_RegWrite_ID(rw_id), .i_ready_stage_ID(rdy_id), .o_stall(stall),
        .o_fwd_sel(fwd_sel), .o_fwd_valid(fwd_valid), .o_stall_count(stall_count));

    forwarding_scoreboard #(.NB_REG(NB_REG), .N_SRC(N_SRC), .DEPTH(7),
                            .NB_SEL(NB_SEL), .NB_CNT(2)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid_ID(v2), .i_flush(1'b0),
        .i_src_ID(src2), .i_src_used_ID(used2), .i_rd_ID(rd2),
        .i_RegWrite_ID(rw2), .i_ready_stage_ID(rdy2), .o_stall(stall2),
        .o_fwd_sel(sel2), .o_fwd_valid(fv2), .o_stall_count(cnt2));

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // The producer of a source is the most recently issued writer still within DEPTH cycles;
    // it is forwardable from pipeline stage "age" once age >= its ready stage.
    function automatic void model_eval(output int sel[N_SRC], output bit hz);
        int src;
        hz = 1'b0;
        for (int s = 0; s < N_SRC; s++) begin
            sel[s] = 0;
            src = int'(src_id[s*NB_REG +: NB_REG]);
            if (used_id[s] && src != 0) begin
                for (int a = 0; a < hist.size(); a++) begin
                    if (hist[a].v && hist[a].w && hist[a].rd == src) begin
                        if (a + 1 < DEPTH) begin
                            sel[s] = a + 1;
                            if (a + 1 < hist[a].rdy) hz = 1'b1;
                        end
                        break;
                    end
                end
            end
        end
    endfunction

    task automatic drive(input bit v, input bit f, input int s0, input int s1, input int u,
                         input int rd, input bit rw, input int rdy);
        valid_id = v;
        flush    = f;
        src_id   = {NB_REG'(s1), NB_REG'(s0)};
        used_id  = N_SRC'(u);
        rd_id    = NB_REG'(rd);
        rw_id    = rw;
        rdy_id   = NB_SEL'(rdy);
    endtask

    task automatic tick();
        int    esel[N_SRC];
        bit    hz, estall, issue;
        hist_t e;
        @(negedge clk);
        model_eval(esel, hz);
        estall = valid_id && !flush && hz;
        issue  = valid_id && !flush && !hz;
        obs_stall = int'(stall);
        check_val("stall", obs_stall, int'(estall));
        @(posedge clk);
        #1;
        e.v   = issue;
        e.rd  = int'(rd_id);
        e.w   = rw_id && (rd_id != 0);
        e.rdy = (rdy_id == 0) ? 1 : int'(rdy_id);
        hist.push_front(e);
        if (hist.size() > DEPTH) void'(hist.pop_back());
        if (estall && mcnt < (1 << NB_CNT) - 1) mcnt++;
        check_val("fwd_valid", int'(fwd_valid), int'(issue));
        for (int s = 0; s < N_SRC; s++)
            check_val("fwd_sel", int'(fwd_sel[s*NB_SEL +: NB_SEL]), issue ? esel[s] : 0);
        check_val("stall_count", int'(stall_count), mcnt);
    endtask

    initial begin
        int c0;
        mcnt = 0;
        #3;
        check_val("rst_stall", int'(stall), 0);
        check_val("rst_valid", int'(fwd_valid), 0);
        check_val("rst_sel", int'(fwd_sel), 0);
        check_val("rst_count", int'(stall_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU dependency
        drive(1, 0, 0, 0, 0, 3, 1, 1); tick();
        drive(1, 0, 3, 0, 1, 0, 0, 1); tick();
        check_val("alu_stall", obs_stall, 0);
        check_val("alu_sel0", int'(fwd_sel[2:0]), 1);
        check_val("alu_valid", int'(fwd_valid), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick(); tick(); tick();

        // Load-use
        drive(1, 0, 0, 0, 0, 5, 1, 2); tick();
        drive(1, 0, 0, 5, 2, 0, 0, 1); tick();
        check_val("lu_stall", obs_stall, 1);
        check_val("lu_bubble", int'(fwd_valid), 0);
        check_val("lu_count", int'(stall_count), 1);
        tick();
        check_val("lu_issue", obs_stall, 0);
        check_val("lu_sel1", int'(fwd_sel[5:3]), 2);

        // Youngest wins, then distance
        drive(1, 0, 0, 0, 0, 7, 1, 1); tick(); tick();
        drive(1, 0, 7, 0, 1, 0, 0, 1); tick();
        check_val("young_sel", int'(fwd_sel[2:0]), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick(); tick(); tick();
        drive(1, 0, 0, 0, 0, 7, 1, 1); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 1); tick(); tick();
        drive(1, 0, 7, 0, 1, 0, 0, 1); tick();
        check_val("far_sel", int'(fwd_sel[2:0]), 0);

        // Zero register / no write / unused operand
        drive(1, 0, 0, 0, 0, 0, 1, 2); tick();
        drive(1, 0, 0, 0, 0, 9, 0, 2); tick();
        drive(1, 0, 0, 9, 3, 0, 0, 1); tick();
        check_val("zero_stall", obs_stall, 0);
        check_val("zero_sel", int'(fwd_sel), 0);
        drive(1, 0, 0, 0, 0, 4, 1, 2); tick();
        drive(1, 0, 4, 4, 0, 0, 0, 1); tick();
        check_val("unused_stall", obs_stall, 0);
        check_val("unused_sel", int'(fwd_sel), 0);

        // Flush overrides a load-use stall
        drive(1, 0, 0, 0, 0, 5, 1, 2); tick();
        c0 = int'(stall_count);
        drive(1, 1, 0, 5, 2, 0, 0, 1); tick();
        check_val("flush_stall", obs_stall, 0);
        check_val("flush_count", int'(stall_count), c0);
        check_val("flush_valid", int'(fwd_valid), 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 4)));
            tick();
        end

        // Asynchronous reset in the middle of a stall
        drive(1, 0, 0, 0, 0, 6, 1, 4); tick();
        drive(1, 0, 6, 0, 1, 0, 0, 1);
        @(negedge clk);
        check_val("pre_rst_stall", int'(stall), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_stall", int'(stall), 0);
        check_val("mid_rst_valid", int'(fwd_valid), 0);
        check_val("mid_rst_sel", int'(fwd_sel), 0);
        check_val("mid_rst_count", int'(stall_count), 0);
        hist.delete();
        mcnt = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick();

        // Counter saturation: DEPTH=7, ready=5 producer gives four stall cycles
        v2 = 1'b1; rd2 = 5'd6; rw2 = 1'b1; rdy2 = 3'd5; used2 = 2'b00; src2 = '0;
        @(posedge clk);
        #1;
        rw2 = 1'b0; rd2 = 5'd0; rdy2 = 3'd1; used2 = 2'b01; src2 = {5'd0, 5'd6};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("sat_stall", int'(stall2), 1);
            @(posedge clk);
            #1;
        end
        check_val("sat_count3", int'(cnt2), 3);
        @(negedge clk);
        check_val("sat_stall4", int'(stall2), 1);
        @(posedge clk);
        #1;
        check_val("sat_hold", int'(cnt2), 3);
        @(negedge clk);
        check_val("sat_release", int'(stall2), 0);
        @(posedge clk);
        #1;
        check_val("sat_sel", int'(sel2[2:0]), 5);
        check_val("sat_valid", int'(fv2), 1);
        v2 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
